seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed scan controller for a multi-digit 7-segment display. Holds a packed BCD value, walks one digit per time slot, and presents the active digit's nibble on D3..D0 for the downstream BCD-to-7-segment decoder, along with a one-hot digit enable. Adds dead time between digits to suppress ghosting, leading-zero blanking, and tear-free updates that take effect only at frame boundaries.

## Interface
- DIGITS, 4: number of display digits, ≥2.
- PRESCALE, 1000: clock cycles per digit slot, > DEAD.
- DEAD, 2: cycles at the start of each slot with all enables off, ≥1.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bcd_in  in  4*DIGITS  packed BCD value; digit i is bits [4i+3:4i]; digit 0 is least significant.
- load  in  1  single-cycle strobe; captures bcd_in and lz_blank into the pending register.
- lz_blank  in  1  enables leading-zero blanking; captured together with load.
- D3, D2, D1, D0  out  1 each  current digit nibble, MSB to LSB, feeding the decoder.
- digit_en  out  DIGITS  one-hot active-high digit select; all-zero during dead time and for blanked digits.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Slot counter cnt runs 0..PRESCALE-1. Digit index idx runs 0..DIGITS-1 and advances when cnt==PRESCALE-1, wrapping from DIGITS-1 to 0.
- Frame: DIGITS slots, idx 0 first. The frame boundary is the cycle with idx==DIGITS-1 and cnt==PRESCALE-1.
- Two-stage value storage:
  - pending: written on every load; the last load wins.
  - shadow: copied from pending at each frame boundary. If load is asserted on the boundary cycle, that cycle's bcd_in/lz_blank go directly into shadow.
  - The displayed value never changes mid-frame.
- A digit is blanked if either:
  - its shadow nibble is >9 (0xA–0xF), or
  - shadow lz_blank=1 and the digit and every more-significant digit are 0. Digit 0 is never blanked by the zero rule.
- Per slot for digit idx:
  - {D3..D0} = shadow nibble idx, or 4'h0 if the digit is blanked. This keeps the decoder out of its undefined default.
  - digit_en = 0 for cnt < DEAD.
  - digit_en = (1<<idx) for cnt ≥ DEAD when not blanked; 0 when blanked.
- Internal states: DEAD (cnt<DEAD) and ON (cnt≥DEAD). DEAD→ON at cnt==DEAD-1; ON→DEAD at the slot end.

## Timing
- All outputs are registered. Every output corresponds to the (idx, cnt) of the same output cycle; the implementation pre-computes one cycle ahead.
- On any cycle with rst=1, the next edge sets:
  - cnt=0, idx=0, pending=0, shadow=0, shadow lz_blank=0.
  - D3..D0=0, digit_en=0, frame_done=0.
- Reset mid-slot or mid-frame aborts immediately, with no completion of the current slot.
- First cycle after rst deasserts = slot cycle 0 of digit 0. digit_en first asserts on cycle DEAD.
- Nibble output changes only on slot cycle 0, which is always inside dead time, so it never changes while any digit_en is high.
- frame_done is high exactly on the frame-boundary cycle: period DIGITS*PRESCALE.
- Load-to-display latency: the new value appears at slot cycle 0 of the first frame starting after the load, i.e. at most DIGITS*PRESCALE cycles later.

## Structure
- Shared package seg_pkg:
  - constants BCD_W=4, BCD_MAX=4'd9, BLANK_NIB=4'h0;
  - function clog2 for idx/cnt widths.
  - The downstream decoder imports the same package.
- Sub-module seg_slot_timer:
  - owns cnt/idx;
  - outputs slot_start, on_phase, frame_end, idx.
- The top level owns pending/shadow, blanking logic and output registers.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, DEAD=2.
- Reset: hold rst 3 cycles. All outputs 0 during reset. After release: cycles 0–1 digit_en=0000, cycles 2–7 digit_en=0001, nibble 0. frame_done first at cycle 31.
- Basic scan: load 16'h1234, lz_blank=0, in frame 0. Frame 1 shows:
  - nibbles 4, 3, 2, 1;
  - digit_en 0001, 0010, 0100, 1000, each for 6 cycles after 2 dead cycles;
  - frame_done every 32 cycles.
- Leading-zero blanking:
  - load 16'h0050 with lz_blank=1: digits 3 and 2 give digit_en 0 and nibble 0; digit 1 shows 5; digit 0 shows 0.
  - load 16'h0000 with lz_blank=1: only digit 0 is lit.
- Invalid BCD: load 16'h12A4. Digit 1 is blanked (nibble 0, enable 0); digits 0, 2, 3 show 4, 2, 1.
- Tearing and boundary:
  - load 16'h1111 then 16'h2222 in the same frame: only 2222 is displayed next frame.
  - load 16'h3333 on the frame_done cycle: displayed in the immediately following frame.
- Reset mid-operation: assert rst at cycle 13 of a frame. Next cycle all outputs are 0 and the shadow is cleared. Scanning restarts at digit 0, cycle 0, showing 0000.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, phase encoding and width helper for the 7-segment scan path.
package seg_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BLANK_NIB = 4'h0;

   typedef enum logic {ST_DEAD, ST_ON} phase_e;

   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: slot counter, digit index and dead/on phase.
// All outputs describe the cycle after the coming edge, so the caller can register on them.
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int DEAD     = 2,
   localparam int IW      = clog2(DIGITS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          slot_start,
   output logic          on_phase,
   output logic          frame_end,
   output logic [IW-1:0] idx
);
   localparam int CW = clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_ON   = CW'(DEAD - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   phase_e        state_q, state_d;

   always_comb begin
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      idx_d   = (cnt_q != CNT_LAST) ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      state_d = (cnt_q == CNT_ON) ? ST_ON : (cnt_q == CNT_LAST) ? ST_DEAD : state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         state_q <= ST_DEAD;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
      end
   end

   assign slot_start = (cnt_d == '0);
   assign on_phase   = (state_d == ST_ON);
   assign frame_end  = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
   assign idx        = idx_d;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scan with dead time, leading-zero blanking
// and frame-synchronous (tear-free) value updates.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int DEAD     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BCD_W*DIGITS-1:0] bcd_in,
   input  logic                    load,
   input  logic                    lz_blank,
   output logic                    D3,
   output logic                    D2,
   output logic                    D1,
   output logic                    D0,
   output logic [DIGITS-1:0]       digit_en,
   output logic                    frame_done
);
   localparam int IW = clog2(DIGITS);
   localparam int W  = BCD_W * DIGITS;

   logic          slot_start, on_phase, frame_end;
   logic [IW-1:0] idx;

   seg_slot_timer #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .slot_start (slot_start),
      .on_phase   (on_phase),
      .frame_end  (frame_end),
      .idx        (idx)
   );

   // MSB of pend/shad holds the captured lz_blank flag
   logic [W:0]       pend_q, pend_d, shad_q, shad_d;
   logic [BCD_W-1:0] nib_q, nib_d, cur;
   logic [DIGITS-1:0] en_q, en_d, blank;
   logic             done_q, done_d, allz;

   always_comb begin
      pend_d = load ? {lz_blank, bcd_in} : pend_q;
      shad_d = done_q ? pend_d : shad_q;
      blank  = '0;
      allz   = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         allz     = allz & (shad_d[BCD_W*i +: BCD_W] == '0);
         blank[i] = (shad_d[BCD_W*i +: BCD_W] > BCD_MAX) || (shad_d[W] && (i != 0) && allz);
      end
      cur    = shad_d[BCD_W*idx +: BCD_W];
      nib_d  = slot_start ? (blank[idx] ? BLANK_NIB : cur) : nib_q;
      en_d   = (on_phase && !blank[idx]) ? DIGITS'(1) << idx : '0;
      done_d = frame_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         shad_q <= '0;
         nib_q  <= '0;
         en_q   <= '0;
         done_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         shad_q <= shad_d;
         nib_q  <= nib_d;
         en_q   <= en_d;
         done_q <= done_d;
      end
   end

   assign {D3, D2, D1, D0} = nib_q;
   assign digit_en         = en_q;
   assign frame_done       = done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and random loads checked every cycle against a
// frame/slot arithmetic model of the display.
module tb_seg_scan_driver;
   localparam int DIGITS = 4, PRESCALE = 8, DEAD = 2, FRAME = DIGITS * PRESCALE;

   logic        clk = 1'b0, rst = 1'b1, load = 1'b0, lz_blank = 1'b0;
   logic [15:0] bcd_in = '0;
   logic        D3, D2, D1, D0, frame_done;
   logic [3:0]  digit_en;

   int          total = 0, bad = 0, t = 0;
   bit          valid = 1'b0;
   logic [16:0] pend = '0, shad = '0;

   seg_scan_driver #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
      .clk        (clk),
      .rst        (rst),
      .bcd_in     (bcd_in),
      .load       (load),
      .lz_blank   (lz_blank),
      .D3         (D3),
      .D2         (D2),
      .D1         (D1),
      .D0         (D0),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic bit blanked(input logic [16:0] s, input int i);
      logic [3:0] n = s[4*i +: 4];
      return (n > 4'd9) || (s[16] && i > 0 && ((s[15:0] >> (4*i)) == 16'h0));
   endfunction

   task automatic cyc(input logic r, input logic ld, input logic [15:0] v, input logic lz);
      int p, i, c;
      bit b;
      logic [3:0] e_nib, e_en;
      logic       e_done;
      @(negedge clk);
      if (valid) begin
         p      = t % FRAME;
         i      = p / PRESCALE;
         c      = p % PRESCALE;
         b      = blanked(shad, i);
         e_nib  = b ? 4'h0 : shad[4*i +: 4];
         e_en   = (c >= DEAD && !b) ? (4'b0001 << i) : 4'b0000;
         e_done = (p == FRAME - 1);
         total++;
         assert ({D3, D2, D1, D0} === e_nib)
            else begin bad++; $error("FAIL nib t=%0d got=%h exp=%h", t, {D3, D2, D1, D0}, e_nib); end
         total++;
         assert (digit_en === e_en)
            else begin bad++; $error("FAIL digit_en t=%0d got=%b exp=%b", t, digit_en, e_en); end
         total++;
         assert (frame_done === e_done)
            else begin bad++; $error("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, e_done); end
      end
      rst      = r;
      load     = ld;
      bcd_in   = v;
      lz_blank = lz;
      if (r) begin
         t = 0; pend = '0; shad = '0; valid = 1'b1;
      end else begin
         if (ld) pend = {lz, v};
         if (t % FRAME == FRAME - 1) shad = pend;
         t++;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic to_pos(input int pos);
      for (int k = 0; k < FRAME && (t % FRAME) != pos; k++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      logic [15:0] v;
      repeat (3) cyc(1'b1, 1'b0, 16'h0, 1'b0);
      idle(3);
      cyc(1'b0, 1'b1, 16'h1234, 1'b0);
      idle(2 * FRAME);
      cyc(1'b0, 1'b1, 16'h0050, 1'b1);
      idle(2 * FRAME);
      cyc(1'b0, 1'b1, 16'h0000, 1'b1);
      idle(2 * FRAME);
      cyc(1'b0, 1'b1, 16'h12A4, 1'b0);
      idle(2 * FRAME);
      to_pos(4);
      cyc(1'b0, 1'b1, 16'h1111, 1'b0);
      idle(5);
      cyc(1'b0, 1'b1, 16'h2222, 1'b0);
      idle(2 * FRAME);
      to_pos(FRAME - 1);
      cyc(1'b0, 1'b1, 16'h3333, 1'b0);
      idle(FRAME + 3);
      to_pos(13);
      cyc(1'b1, 1'b0, 16'h0, 1'b0);
      idle(2 * FRAME);
      for (int k = 0; k < 2000; k++) begin
         v = 16'($urandom);
         if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
         if ($urandom_range(0, 1) == 0) v = v & 16'h7777;
         cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0), v, 1'($urandom));
      end
      idle(FRAME + 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
